key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_if.sv | 26 ++
 rtl/key_debounce.sv | 85 ++++++++
 2 files changed

// File: rtl/key_debounce_if.sv
// key_debounce_if: raw active-low key inputs and debounced per-key level/event outputs
interface key_debounce_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;

    modport master (
        output key_n,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_n,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: per-key synchronizer, debounce filter, press/release/long-press pulse generation
module key_debounce #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000
) (
    input logic                  clk,
    input logic                  rst_n,
    key_debounce_if.slave        keys
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);

    logic [N_KEYS-1:0] level_vec;
    logic [N_KEYS-1:0] press_vec;
    logic [N_KEYS-1:0] release_vec;
    logic [N_KEYS-1:0] long_vec;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
        logic          sync1_q;
        logic          sync2_q;
        logic          level_q;
        logic          level_d;
        logic          press_q;
        logic          press_d;
        logic          release_q;
        logic          release_d;
        logic          long_q;
        logic          long_d;
        logic [DW-1:0] deb_q;
        logic [DW-1:0] deb_d;
        logic [HW-1:0] hold_q;
        logic [HW-1:0] hold_d;
        logic          differ;
        logic          flip;

        // debounce and hold next-state; a release on the threshold cycle wins over key_long
        always_comb begin
            differ    = (~sync2_q) != level_q;
            flip      = differ && (deb_q == DEB_MAX);
            deb_d     = (!differ || flip) ? '0 : deb_q + 1'b1;
            level_d   = level_q ^ flip;
            press_d   = flip && !level_q;
            release_d = flip && level_q;
            hold_d    = !level_q ? '0 : (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
            long_d    = level_q && !flip && (hold_q == HOLD_PRE);
        end

        // synchronizer, counters and registered outputs; reset restores the released state
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1_q   <= 1'b1;
                sync2_q   <= 1'b1;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                deb_q     <= '0;
                hold_q    <= '0;
            end else begin
                sync1_q   <= keys.key_n[k];
                sync2_q   <= sync1_q;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
                deb_q     <= deb_d;
                hold_q    <= hold_d;
            end
        end

        assign level_vec[k]   = level_q;
        assign press_vec[k]   = press_q;
        assign release_vec[k] = release_q;
        assign long_vec[k]    = long_q;
    end

    assign keys.key_level   = level_vec;
    assign keys.key_press   = press_vec;
    assign keys.key_release = release_vec;
    assign keys.key_long    = long_vec;
endmodule
